uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data-memory port, in parallel with data RAM.
//  - Consumes the CPU's address/write-data/byte-mask/write-enable.
//  - Buffers bytes in a FIFO and serialises them 8N1, LSB first, on txd.
//  - Read data is combinational, because the core is single-cycle.

---
 rtl/uart_tx_mmio_pkg.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx_mmio.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants, status layout and helpers for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

  localparam int unsigned UART_DIV_W = 16;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] UART_OFF_DATA   = 2'd0;
  localparam logic [1:0] UART_OFF_STATUS = 2'd1;
  localparam logic [1:0] UART_OFF_BAUD   = 2'd2;
  localparam logic [1:0] UART_OFF_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int unsigned UART_STAT_FULL   = 0;
  localparam int unsigned UART_STAT_EMPTY  = 1;
  localparam int unsigned UART_STAT_BUSY   = 2;
  localparam int unsigned UART_STAT_OVF    = 3;
  localparam int unsigned UART_STAT_PARITY = 4;

  // Transmit FSM encodings
  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  // Field order matches the UART_STAT_* bit positions (full is bit 0)
  typedef struct packed {
    logic par_present;
    logic overflow;
    logic busy;
    logic empty;
    logic full;
  } uart_status_t;

  // Per-lane divisor update; a zero result is clamped to 1
  function automatic logic [UART_DIV_W-1:0] uart_baud_merge(
    input logic [UART_DIV_W-1:0] cur,
    input logic [UART_DIV_W-1:0] wd,
    input logic [1:0]            mask
  );
    logic [UART_DIV_W-1:0] v;
    v = cur;
    if (mask[0]) v[7:0]  = wd[7:0];
    if (mask[1]) v[15:8] = wd[15:8];
    if (v == '0) v = UART_DIV_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; push is ignored when full, pop when empty.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;
  assign dout      = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (pop_ok_c)  rd_ptr <= AW'(rd_ptr + AW'(1));
      count <= CW'(count + CW'(push_ok_c) - CW'(pop_ok_c));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0]           BASE_ADDR  = 32'hF000_0000,
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter logic [UART_DIV_W-1:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  input  logic [3:0]  wrMask,
  input  logic        we,
  output logic        sel,
  output logic [31:0] readData,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  logic [1:0]            off_c;
  logic                  wr_c;
  logic                  push_c;
  logic                  push_ok_c;
  logic                  pop_c;
  logic                  ovf_clr_c;
  logic                  baud_wr_c;
  logic                  irq_n_c;
  logic                  unused_bits_c;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [7:0]            fifo_dout;

  logic [2:0]            state, state_n;
  logic [UART_DIV_W-1:0] baud_cnt, baud_cnt_n;
  logic [7:0]            shift, shift_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic                  txd_n;
  logic [UART_DIV_W-1:0] divisor;
  logic [UART_DIV_W-1:0] reload_c;
  logic                  overflow;
  uart_status_t          status_c;

  // Address decode and write strobes
  assign sel           = (addr[31:4] == BASE_ADDR[31:4]);
  assign off_c         = addr[3:2];
  assign wr_c          = we && sel;
  assign push_c        = wr_c && (off_c == UART_OFF_DATA) && wrMask[0];
  assign push_ok_c     = push_c && !fifo_full;
  assign ovf_clr_c     = wr_c && (off_c == UART_OFF_STATUS) && wrMask[0]
                         && writeData[UART_STAT_OVF];
  assign baud_wr_c     = wr_c && (off_c == UART_OFF_BAUD) && (|wrMask[1:0]);
  assign reload_c      = UART_DIV_W'(divisor - UART_DIV_W'(1));
  assign unused_bits_c = ^{addr[1:0], writeData[31:16], wrMask[3:2]};

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .din   (writeData[7:0]),
    .pop   (pop_c),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

  always_comb begin
    status_c             = '0;
    status_c.full        = fifo_full;
    status_c.empty       = fifo_empty;
    status_c.busy        = (state != UART_ST_IDLE);
    status_c.overflow    = overflow;
    status_c.par_present = PARITY_PRESENT;
  end

  // Register read mux, combinational for the single-cycle core
  always_comb begin
    readData = '0;
    if (sel) begin
      case (off_c)
        UART_OFF_STATUS: readData = 32'(status_c);
        UART_OFF_BAUD:   readData = 32'(divisor);
        UART_OFF_RSVD:   readData = '0;
        default:         readData = '0;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (reset)      par_bit <= 1'b0;
    else if (pop_c) par_bit <= ^fifo_dout;
  end
`endif

  // Next-state logic; every state holds for exactly divisor cycles
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    txd_n      = txd;
    pop_c      = 1'b0;
    case (state)
      UART_ST_IDLE: begin
        txd_n = 1'b1;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          shift_n    = fifo_dout;
          state_n    = UART_ST_START;
          txd_n      = 1'b0;
          baud_cnt_n = reload_c;
        end
      end
      UART_ST_START: begin
        if (baud_cnt == '0) begin
          state_n    = UART_ST_DATA;
          txd_n      = shift[0];
          shift_n    = {1'b0, shift[7:1]};
          bit_idx_n  = '0;
          baud_cnt_n = reload_c;
        end else begin
          baud_cnt_n = UART_DIV_W'(baud_cnt - UART_DIV_W'(1));
        end
      end
      UART_ST_DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = reload_c;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = UART_ST_PARITY;
            txd_n   = par_bit;
`else
            state_n = UART_ST_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            txd_n     = shift[0];
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = 3'(bit_idx + 3'd1);
          end
        end else begin
          baud_cnt_n = UART_DIV_W'(baud_cnt - UART_DIV_W'(1));
        end
      end
`ifdef UART_PARITY_EN
      UART_ST_PARITY: begin
        if (baud_cnt == '0) begin
          state_n    = UART_ST_STOP;
          txd_n      = 1'b1;
          baud_cnt_n = reload_c;
        end else begin
          baud_cnt_n = UART_DIV_W'(baud_cnt - UART_DIV_W'(1));
        end
      end
`endif
      UART_ST_STOP: begin
        txd_n = 1'b1;
        if (baud_cnt == '0) begin
          state_n = UART_ST_IDLE;
        end else begin
          baud_cnt_n = UART_DIV_W'(baud_cnt - UART_DIV_W'(1));
        end
      end
      default: begin
        state_n = UART_ST_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  // irq reflects the FIFO and FSM state being entered this edge
  assign irq_n_c = (CNT_W'(fifo_count + CNT_W'(push_ok_c) - CNT_W'(pop_c)) == '0)
                   && (state_n == UART_ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UART_ST_IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      txd      <= 1'b1;
      irq      <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      txd      <= txd_n;
      irq      <= irq_n_c;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      divisor  <= DIV_RESET;
    end else begin
      if (push_c && fifo_full) overflow <= 1'b1;
      else if (ovf_clr_c)      overflow <= 1'b0;
      if (baud_wr_c) divisor <= uart_baud_merge(divisor, writeData[15:0], wrMask[1:0]);
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed and randomized bench for uart_tx_mmio with a frame-level serial model.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'hF000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_BAUD = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;
`ifdef UART_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam logic [31:0] STAT_IDLE = {27'd0, PAR, 4'b0010};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [3:0]  wrMask;
  logic        we;
  logic        sel;
  logic [31:0] readData;
  logic        txd;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] s;
  logic [7:0]  rb;
  bit          rok;
  logic [7:0]  exp_q[$];
  logic [7:0]  v;
  int          d;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .writeData (writeData),
    .wrMask    (wrMask),
    .we        (we),
    .sel       (sel),
    .readData  (readData),
    .txd       (txd),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] m);
    addr = a; writeData = dat; wrMask = m; we = 1'b1;
    step();
    we = 1'b0; wrMask = 4'b0; writeData = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat);
    addr = a;
    #1;
    dat = readData;
  endtask

  // Serial frame model: start, 8 data bits LSB first, optional even parity, stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic send_and_check(input logic [7:0] b, input int dv, input string tag);
    logic [31:0] st;
    wr(A_DATA, {24'h0, b}, 4'b0001);
    check({tag, "_txd_pre"}, 32'(txd), 32'(1));
    for (int i = 0; i < NBITS * dv; i++) begin
      step();
      rd(A_STAT, st);
      check($sformatf("%s_txd%0d", tag, i), 32'(txd), 32'(frame_bit(b, i / dv)));
      check($sformatf("%s_busy%0d", tag, i), 32'(st[2]), 32'(1));
    end
    step();
    rd(A_STAT, st);
    check({tag, "_busy_end"}, 32'(st[2]), 32'(0));
    check({tag, "_irq_end"}, 32'(irq), 32'(1));
    check({tag, "_txd_end"}, 32'(txd), 32'(1));
  endtask

  // Bit-period receiver: waits for a start bit, then samples each bit's first cycle
  task automatic recv(input int dv, input string tag, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int t = 0; t < 300; t++) begin
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) return;
    for (int k = 0; k < 8; k++) begin
      repeat (dv) step();
      b[k] = txd;
    end
    if (PAR) begin
      repeat (dv) step();
      check({tag, "_par"}, 32'(txd), 32'(^b));
    end
    repeat (dv) step();
    check({tag, "_stop"}, 32'(txd), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = '0; writeData = '0; wrMask = '0; we = 1'b0;

    // Reset state
    repeat (2) step();
    reset = 1'b0;
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_irq", 32'(irq), 32'(1));
    rd(A_STAT, s);  check("rst_status", s, STAT_IDLE);
    rd(A_BAUD, s);  check("rst_baud", s, 32'd868);
    check("sel_base", 32'(sel), 32'(1));
    rd(32'h0000_0100, s);
    check("sel_out", 32'(sel), 32'(0));
    check("rd_out", s, 32'd0);
    rd(A_DATA, s);  check("rd_data_zero", s, 32'd0);

    // Directed frame 0xA5 at divisor 4
    wr(A_BAUD, 32'd4, 4'b0011);
    rd(A_BAUD, s);  check("baud4", s, 32'd4);
    send_and_check(8'hA5, 4, "a5");

    // Random bytes at random divisors
    for (int n = 0; n < 3; n++) begin
      d = int'($urandom_range(1, 5));
      v = 8'($urandom);
      wr(A_BAUD, 32'(d), 4'b0011);
      send_and_check(v, d, $sformatf("rnd%0d", n));
    end

    // Overflow: first frame pops at once, then 8 fit and the 9th is rejected
    wr(A_BAUD, 32'd1, 4'b0011);
    exp_q.delete();
    v = 8'($urandom);
    exp_q.push_back(v);
    wr(A_DATA, {24'h0, v}, 4'b0001);
    fork
      begin
        for (int k = 0; k < 9; k++) begin
          recv(1, $sformatf("rx%0d", k), rb, rok);
          check($sformatf("rx%0d_seen", k), 32'(rok), 32'(1));
          check($sformatf("rx%0d_byte", k), 32'(rb), 32'(exp_q[k]));
        end
      end
      begin
        for (int k = 0; k < 9; k++) begin
          v = 8'($urandom);
          if (k < 8) exp_q.push_back(v);
          wr(A_DATA, {24'h0, v}, 4'b0001);
        end
        rd(A_STAT, s);
        check("flood_full", 32'(s[0]), 32'(1));
        check("flood_empty", 32'(s[1]), 32'(0));
        check("flood_ovf", 32'(s[3]), 32'(1));
        wr(A_STAT, 32'h8, 4'b0001);
        rd(A_STAT, s);
        check("ovf_clear", 32'(s[3]), 32'(0));
      end
    join
    repeat (3) step();
    rd(A_STAT, s);  check("drain_status", s, STAT_IDLE);
    check("drain_irq", 32'(irq), 32'(1));

    // Divisor lanes, zero clamp, masked DATA write, reserved register
    wr(A_BAUD, 32'h0, 4'b0011);
    rd(A_BAUD, s);  check("baud_zero", s, 32'd1);
    wr(A_BAUD, 32'hFFFF_1234, 4'b0001);
    rd(A_BAUD, s);  check("baud_lane0", s, 32'h0034);
    wr(A_BAUD, 32'h0000_AB00, 4'b0010);
    rd(A_BAUD, s);  check("baud_lane1", s, 32'hAB34);
    wr(A_BAUD, 32'h0, 4'b1100);
    rd(A_BAUD, s);  check("baud_upper_mask", s, 32'hAB34);
    wr(A_DATA, 32'h0000_5500, 4'b0010);
    repeat (2) step();
    rd(A_STAT, s);  check("mask_nopush", s, STAT_IDLE);
    check("mask_txd", 32'(txd), 32'(1));
    wr(A_RSVD, 32'hFFFF_FFFF, 4'b1111);
    rd(A_RSVD, s);  check("rsvd_zero", s, 32'd0);
    rd(A_BAUD, s);  check("rsvd_noeffect", s, 32'hAB34);
    rd(BASE + 32'h10, s);
    check("sel_next_block", 32'(sel), 32'(0));

    // Parity (or direct stop) after bit 7
    wr(A_BAUD, 32'd2, 4'b0011);
    send_and_check(8'h07, 2, "b07");

    // Reset during data bit 3 with 3 bytes still queued
    wr(A_BAUD, 32'd4, 4'b0011);
    for (int k = 0; k < 4; k++) wr(A_DATA, 32'($urandom_range(0, 255)), 4'b0001);
    repeat (14) step();
    rd(A_STAT, s);  check("pre_rst_busy", 32'(s[2]), 32'(1));
    reset = 1'b1;
    step();
    check("midrst_txd", 32'(txd), 32'(1));
    check("midrst_irq", 32'(irq), 32'(1));
    rd(A_STAT, s);  check("midrst_status", s, STAT_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      check($sformatf("postrst_txd%0d", i), 32'(txd), 32'(1));
    end
    rd(A_STAT, s);  check("postrst_status", s, STAT_IDLE);
    rd(A_BAUD, s);  check("postrst_baud", s, 32'd868);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
